// File: rtl/product_accumulator.sv
// Sums a burst of up to MAX_TERMS unsigned products and holds the total on a valid/ready output.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum at all ones instead of wrapping.
module product_accumulator #(
    parameter int PWIDTH    = 64,
    parameter int AWIDTH    = 72,
    parameter int MAX_TERMS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PWIDTH-1:0]              product,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [AWIDTH-1:0]              acc_out,
    output logic [$clog2(MAX_TERMS+1)-1:0] term_count,
    output logic                           overflow,
    output logic                           state_dbg
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    // Handshake: a beat moves when in_valid && in_ready; the sum moves when out_valid && out_ready.
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_next;
    logic [AWIDTH:0]   sum;
    logic [AWIDTH-1:0] acc_next;
    logic [CW-1:0]     count_next;
    logic              ovf_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            acc_out    <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            acc_out    <= acc_next;
            term_count <= count_next;
            overflow   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sum        = '0;
        acc_next   = acc_out;
        count_next = term_count;
        ovf_next   = overflow;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                // product only enters the datapath on an accepted beat
                if (in_valid) begin
                    sum        = {1'b0, acc_out} + (AWIDTH + 1)'(product);
                    count_next = term_count + 1'b1;
                    acc_next   = sum[AWIDTH-1:0];
                    if (sum[AWIDTH]) begin
                        ovf_next = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        acc_next = '1;
`else
                        acc_next = sum[AWIDTH-1:0];
`endif
                    end
                    if (in_last || count_next == CW'(MAX_TERMS)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign state_dbg = (state == HOLD);

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the pipelined multiplier's product bus.
- Sums a burst of up to MAX_TERMS products into one wide accumulator.
- Presents the finished sum on a valid/ready output handshake. Used for dot-product and MAC operations.
- Upstream valid tracking, which aligns in_valid with the multiplier's output register, lives outside this block.

Parameters:
- PWIDTH, 64: width of the incoming product.
- AWIDTH, 72: accumulator width; must be at least PWIDTH.
- MAX_TERMS, 16: maximum number of products per burst; must be 2 or more.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat is present.
- in_ready  output  1  block can accept a beat.
- product  input  PWIDTH  unsigned product from the multiplier.
- in_last  input  1  marks the final beat of a burst.
- out_valid  output  1  sum is available.
- out_ready  input  1  consumer takes the sum.
- acc_out  output  AWIDTH  accumulated sum.
- term_count  output  $clog2(MAX_TERMS+1)  number of beats in the current or held burst.
- overflow  output  1  sticky flag: the sum exceeded AWIDTH during this burst.

Behaviour:
- One clock. Reset is synchronous and active-high, sampled only at the rising edge of clk.
- On reset:
  - state = ACCUM
  - acc_out = 0, term_count = 0, overflow = 0
  - out_valid = 0, in_ready = 1
- Reset asserted mid-burst or while holding a result discards everything; there is no partial output.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - A beat is accepted when in_valid && in_ready.
  - On accept: acc <= acc + zero-extended product, computed at AWIDTH+1 bits; term_count <= term_count + 1.
  - If the carry out of bit AWIDTH-1 is 1, overflow <= 1 and acc keeps the wrapped low AWIDTH bits.
  - Go to HOLD on an accepted beat with in_last = 1, or when the accepted beat brings term_count to MAX_TERMS (forced close).
  - in_last without in_valid is ignored.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - acc_out, term_count and overflow are stable and show the final burst values.
  - in_valid is ignored and the upstream must stall.
  - When out_ready = 1: acc <= 0, term_count <= 0, overflow <= 0, go to ACCUM. in_ready rises the next cycle.
- Latency: out_valid asserts exactly 1 cycle after the closing beat is accepted.
- Minimum burst is 1 beat. Peak throughput is one burst per (N + 1) cycles when out_ready is held high, because the HOLD cycle accepts no beat.
- out_ready while out_valid = 0 has no effect.
- acc_out, term_count and overflow are registered outputs; acc_out shows the running sum during ACCUM.
- No X propagation: product is used only on an accepted beat.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: when the AWIDTH+1-bit sum carries out, acc <= all ones (2^AWIDTH - 1) and overflow <= 1. Later beats in the same burst keep acc saturated.
- Undefined: the sum wraps modulo 2^AWIDTH and overflow <= 1, as described in Behaviour.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then 3 beats of 5, 7, 11 with in_last on the third and out_ready = 1 → out_valid one cycle after the third beat; acc_out = 23, term_count = 3, overflow = 0; in_ready back to 1 the following cycle.
- Burst of 16 beats of value 1 with in_last never asserted → forced close; acc_out = 16, term_count = 16; a 17th beat offered is stalled (in_ready = 0) until out_ready.
- AWIDTH = 64: beats 0xFFFF_FFFF_FFFF_FFFF then 2 with last →
  - without the macro: acc_out = 1, overflow = 1;
  - with PRODUCT_ACCUMULATOR_SATURATE_EN: acc_out = 0xFFFF_FFFF_FFFF_FFFF, overflow = 1.
- HOLD with out_ready = 0 for 5 cycles while in_valid = 1 with product 9 → acc_out unchanged, in_ready = 0 throughout, no beat lost; after out_ready the next burst starts from 0 and its first beat of 9 gives acc_out = 9.
- Assert reset for 1 cycle after 2 beats (4, 6) → acc_out = 0, term_count = 0, out_valid never asserts; a following single beat of 3 with last → acc_out = 3, term_count = 1.
- Single-beat burst of 0x1234 with last, then out_ready pulsed in the same cycle out_valid rises → handshake completes in 1 cycle; state returns to ACCUM with acc_out = 0.
